// File: rtl/canvas_sequencer.sv
// Canvas-to-classifier sequencer: freezes the drawing canvas, streams its pixels
// row-major to the NN as valid/ready beats, then latches (or times out on) the result.
module canvas_sequencer #(
  parameter int N_DIM   = 28,
  parameter int PIX_MAX = 2047,
  parameter int TIMEOUT = 1048575
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Start,
  input  logic        Clear,
  input  logic        Draw_Req,
  output logic        Draw_En,
  output logic        Canvas_Clear,
  output logic [4:0]  Pix_X,
  output logic [4:0]  Pix_Y,
  input  logic [15:0] Pix_Data,
  output logic        Px_Valid,
  input  logic        Px_Ready,
  output logic [15:0] Px_Data,
  output logic        Px_Last,
  input  logic        Res_Valid,
  input  logic [3:0]  Res_Digit,
  output logic [3:0]  Digit,
  output logic        Digit_Valid,
  output logic        Busy,
  output logic        Timeout
);

  localparam int              CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]   TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [4:0]      LAST    = 5'(N_DIM - 1);
  localparam logic [15:0]     SAT     = 16'(PIX_MAX);

  typedef enum logic [1:0] {IDLE, CLEAR, STREAM, WAIT_RES} state_t;

  state_t        r_state, w_state_nxt;
  logic [4:0]    r_pix_x, r_pix_y;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_digit;
  logic          r_digit_vld, r_timeout;
  logic          w_xfer, w_last, w_to;

  // All handshake outputs decode straight from the state register, so an
  // asynchronous reset drops Px_Valid in the same instant.
  assign Px_Valid     = (r_state == STREAM);
  assign Busy         = (r_state == STREAM) || (r_state == WAIT_RES);
  assign Canvas_Clear = (r_state == CLEAR);
  assign Draw_En      = Draw_Req && (r_state == IDLE);
  assign w_last       = (r_pix_x == LAST) && (r_pix_y == LAST);
  assign Px_Last      = Px_Valid && w_last;
  assign w_xfer       = Px_Valid && Px_Ready;
  assign Px_Data      = (Pix_Data > SAT) ? SAT : Pix_Data;
  assign w_to         = (r_cnt == TO_LAST);
  assign Pix_X        = r_pix_x;
  assign Pix_Y        = r_pix_y;
  assign Digit        = r_digit;
  assign Digit_Valid  = r_digit_vld;
  assign Timeout      = r_timeout;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (Clear) w_state_nxt = CLEAR;
                else if (Start) w_state_nxt = STREAM;
      CLEAR:    w_state_nxt = IDLE;
      STREAM:   if (Clear) w_state_nxt = CLEAR;
                else if (w_xfer && w_last) w_state_nxt = WAIT_RES;
      WAIT_RES: if (Clear) w_state_nxt = CLEAR;
                else if (Res_Valid || w_to) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= IDLE;
      r_pix_x     <= '0;
      r_pix_y     <= '0;
      r_cnt       <= '0;
      r_digit     <= 4'hF;
      r_digit_vld <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (Draw_En) r_digit_vld <= 1'b0;
          if (!Clear && Start) begin
            r_pix_x     <= '0;
            r_pix_y     <= '0;
            r_digit_vld <= 1'b0;
          end
        end
        CLEAR: begin
          r_digit     <= 4'hF;
          r_digit_vld <= 1'b0;
          r_timeout   <= 1'b0;
        end
        STREAM: begin
          r_cnt <= '0;
          if (!Clear && w_xfer) begin
            if (r_pix_x == LAST) begin
              r_pix_x <= '0;
              r_pix_y <= (r_pix_y == LAST) ? 5'd0 : r_pix_y + 5'd1;
            end else begin
              r_pix_x <= r_pix_x + 5'd1;
            end
          end
        end
        WAIT_RES: begin
          // Timeout fires on the cycle the count would reach TIMEOUT, giving
          // exactly TIMEOUT cycles in WAIT_RES; a same-cycle result wins.
          if (!Clear) begin
            if (Res_Valid) begin
              r_digit     <= (Res_Digit <= 4'd9) ? Res_Digit : 4'hF;
              r_digit_vld <= (Res_Digit <= 4'd9);
              r_timeout   <= 1'b0;
            end else if (w_to) begin
              r_digit     <= 4'hF;
              r_digit_vld <= 1'b0;
              r_timeout   <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_canvas_sequencer.sv
// Directed bench for canvas_sequencer: full/stalled streams, timeout, clear/abort,
// draw gating and mid-stream reset, against hand-computed beat values.
module tb_canvas_sequencer;

  logic        Clk = 1'b0, Reset_n = 1'b0;
  logic        Start = 0, Clear = 0, Draw_Req = 0, Px_Ready = 0, Res_Valid = 0;
  logic [3:0]  Res_Digit = 0;
  logic        Draw_En, Canvas_Clear, Px_Valid, Px_Last, Digit_Valid, Busy, Timeout;
  logic [4:0]  Pix_X, Pix_Y;
  logic [15:0] Pix_Data, Px_Data;
  logic [3:0]  Digit;
  int          n_cmp = 0, n_bad = 0;

  always #5 Clk = ~Clk;

  // Sparse canvas: value by (x,y)
  assign Pix_Data = (Pix_X == 0  && Pix_Y == 0)  ? 16'd3000 :
                    (Pix_X == 3  && Pix_Y == 5)  ? 16'd1000 :
                    (Pix_X == 2  && Pix_Y == 0)  ? 16'd2048 :
                    (Pix_X == 8  && Pix_Y == 14) ? 16'd55   :
                    (Pix_X == 27 && Pix_Y == 27) ? 16'd2047 : 16'd0;

  canvas_sequencer #(.N_DIM(28), .PIX_MAX(2047), .TIMEOUT(100)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Clear(Clear), .Draw_Req(Draw_Req),
    .Draw_En(Draw_En), .Canvas_Clear(Canvas_Clear), .Pix_X(Pix_X), .Pix_Y(Pix_Y),
    .Pix_Data(Pix_Data), .Px_Valid(Px_Valid), .Px_Ready(Px_Ready), .Px_Data(Px_Data),
    .Px_Last(Px_Last), .Res_Valid(Res_Valid), .Res_Digit(Res_Digit), .Digit(Digit),
    .Digit_Valid(Digit_Valid), .Busy(Busy), .Timeout(Timeout));

  // Hand-computed expected beat values (beat = y*28 + x)
  function automatic logic [15:0] exp_beat(input int b);
    case (b)
      0:       return 16'd2047;
      2:       return 16'd2047;
      143:     return 16'd1000;
      400:     return 16'd55;
      783:     return 16'd2047;
      default: return 16'd0;
    endcase
  endfunction

  // Starts a stream and follows it; returns at the negedge where beats==abort_at
  // (abort_at<0: run to completion). mode 1 = ready 1-of-3 cycles.
  task automatic stream(input int mode, input int abort_at, output int beats, output int errs);
    logic [15:0] held;
    bit stalled;
    beats = 0; errs = 0; stalled = 0; held = '0;
    @(negedge Clk); Start = 1;
    @(negedge Clk); Start = 0;
    for (int cyc = 0; cyc < 4000 && beats < 784; cyc++) begin
      if (abort_at >= 0 && beats == abort_at) return;
      Px_Ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      #1;
      if (stalled && Px_Data !== held) errs++;
      if (Px_Valid !== 1'b1 || Pix_X !== 5'(beats % 28) || Pix_Y !== 5'(beats / 28) ||
          Px_Data !== exp_beat(beats) || Px_Last !== (beats == 783)) begin
        if (errs == 0)
          $display("FAIL beat %0d: x=%0d y=%0d data=%0d last=%b vld=%b, want data=%0d last=%b",
                   beats, Pix_X, Pix_Y, Px_Data, Px_Last, Px_Valid, exp_beat(beats), beats == 783);
        errs++;
      end
      if (Px_Ready) begin beats++; stalled = 0; end
      else begin stalled = 1; held = Px_Data; end
      @(negedge Clk);
    end
    Px_Ready = 0;
  endtask

  task automatic test_reset;
    logic [19:0] v;
    @(negedge Clk);
    v = {Px_Valid, Px_Last, Canvas_Clear, Busy, Digit_Valid, Timeout, Digit, Pix_X, Pix_Y};
    n_cmp++;
    if (v !== {6'b0, 4'hF, 10'b0}) begin n_bad++; $display("FAIL reset_state: got %h want %h", v, {6'b0, 4'hF, 10'b0}); end
    Reset_n = 1;
    @(negedge Clk);
  endtask

  task automatic test_stream_basic;
    int b, e;
    stream(0, -1, b, e);
    n_cmp++;
    if (b !== 784 || e !== 0) begin n_bad++; $display("FAIL basic_stream: beats=%0d errs=%0d want 784/0", b, e); end
    n_cmp++;
    if (Px_Valid !== 0 || Busy !== 1) begin n_bad++; $display("FAIL wait_entry: vld=%b busy=%b want 0/1", Px_Valid, Busy); end
    Res_Valid = 1; Res_Digit = 7;
    @(negedge Clk); Res_Valid = 0;
    n_cmp++;
    if (Digit !== 4'd7 || Digit_Valid !== 1 || Busy !== 0 || Timeout !== 0) begin
      n_bad++; $display("FAIL result_7: digit=%h dv=%b busy=%b to=%b want 7/1/0/0", Digit, Digit_Valid, Busy, Timeout);
    end
    Res_Valid = 1; Res_Digit = 3;
    @(negedge Clk); Res_Valid = 0;
    n_cmp++;
    if (Digit !== 4'd7 || Digit_Valid !== 1) begin n_bad++; $display("FAIL res_outside_wait: digit=%h dv=%b want 7/1", Digit, Digit_Valid); end
  endtask

  task automatic test_stall;
    int b, e;
    stream(1, -1, b, e);
    n_cmp++;
    if (b !== 784 || e !== 0) begin n_bad++; $display("FAIL stall_stream: beats=%0d errs=%0d want 784/0", b, e); end
    n_cmp++;
    if (Digit_Valid !== 0) begin n_bad++; $display("FAIL dv_cleared_on_stream: dv=%b want 0", Digit_Valid); end
    Res_Valid = 1; Res_Digit = 4'd12;
    @(negedge Clk); Res_Valid = 0;
    n_cmp++;
    if (Digit !== 4'hF || Digit_Valid !== 0 || Busy !== 0) begin
      n_bad++; $display("FAIL result_12: digit=%h dv=%b busy=%b want f/0/0", Digit, Digit_Valid, Busy);
    end
  endtask

  task automatic test_timeout;
    int b, e, n;
    stream(0, -1, b, e);
    n = 0;
    while (Busy && n < 300) begin
      n++;
      Start = (n == 10);
      @(negedge Clk);
    end
    Start = 0;
    n_cmp++;
    if (n !== 100) begin n_bad++; $display("FAIL timeout_cycles: got %0d want 100", n); end
    n_cmp++;
    if (Digit !== 4'hF || Timeout !== 1 || Digit_Valid !== 0 || Px_Valid !== 0) begin
      n_bad++; $display("FAIL timeout_state: digit=%h to=%b dv=%b vld=%b want f/1/0/0", Digit, Timeout, Digit_Valid, Px_Valid);
    end
  endtask

  task automatic test_start_clear;
    Start = 1; Clear = 1;
    @(negedge Clk); Start = 0; Clear = 0;
    n_cmp++;
    if (Canvas_Clear !== 1 || Px_Valid !== 0) begin n_bad++; $display("FAIL clear_pulse: cc=%b vld=%b want 1/0", Canvas_Clear, Px_Valid); end
    @(negedge Clk);
    n_cmp++;
    if (Canvas_Clear !== 0 || Px_Valid !== 0 || Busy !== 0 || Timeout !== 0) begin
      n_bad++; $display("FAIL clear_done: cc=%b vld=%b busy=%b to=%b want 0/0/0/0", Canvas_Clear, Px_Valid, Busy, Timeout);
    end
  endtask

  task automatic test_abort;
    int b, e;
    stream(0, 400, b, e);
    Px_Ready = 1; Clear = 1; #1;
    n_cmp++;
    if (b !== 400 || e !== 0 || Pix_X !== 5'd8 || Pix_Y !== 5'd14 || Px_Data !== 16'd55) begin
      n_bad++; $display("FAIL beat_400: beats=%0d errs=%0d x=%0d y=%0d data=%0d want 400/0/8/14/55", b, e, Pix_X, Pix_Y, Px_Data);
    end
    @(negedge Clk); Clear = 0; Px_Ready = 0;
    n_cmp++;
    if (Px_Valid !== 0 || Canvas_Clear !== 1) begin n_bad++; $display("FAIL abort_clear: vld=%b cc=%b want 0/1", Px_Valid, Canvas_Clear); end
    @(negedge Clk);
    n_cmp++;
    if (Canvas_Clear !== 0 || Busy !== 0) begin n_bad++; $display("FAIL abort_idle: cc=%b busy=%b want 0/0", Canvas_Clear, Busy); end
  endtask

  task automatic test_draw;
    int n;
    Start = 1;
    @(negedge Clk); Start = 0; Draw_Req = 1; Px_Ready = 0; #1;
    n_cmp++;
    if (Draw_En !== 0 || Busy !== 1) begin n_bad++; $display("FAIL draw_in_stream: de=%b busy=%b want 0/1", Draw_En, Busy); end
    Draw_Req = 0; Px_Ready = 1; n = 0;
    @(negedge Clk);
    while (Px_Valid && n < 1000) begin n++; @(negedge Clk); end
    Px_Ready = 0;
    n_cmp++;
    if (n !== 783 || Busy !== 1) begin n_bad++; $display("FAIL draw_stream_len: cycles=%0d busy=%b want 783/1", n, Busy); end
    Res_Valid = 1; Res_Digit = 4'd4;
    @(negedge Clk); Res_Valid = 0; Draw_Req = 1; #1;
    n_cmp++;
    if (Draw_En !== 1 || Digit !== 4'd4 || Digit_Valid !== 1) begin
      n_bad++; $display("FAIL draw_idle: de=%b digit=%h dv=%b want 1/4/1", Draw_En, Digit, Digit_Valid);
    end
    @(negedge Clk); Draw_Req = 0;
    n_cmp++;
    if (Digit_Valid !== 0) begin n_bad++; $display("FAIL draw_stale: dv=%b want 0", Digit_Valid); end
  endtask

  task automatic test_reset_mid;
    int b, e;
    logic [19:0] v;
    stream(0, 200, b, e);
    Px_Ready = 1; Reset_n = 0; #1;
    v = {Px_Valid, Px_Last, Canvas_Clear, Busy, Digit_Valid, Timeout, Digit, Pix_X, Pix_Y};
    n_cmp++;
    if (b !== 200 || v !== {6'b0, 4'hF, 10'b0}) begin n_bad++; $display("FAIL reset_mid: beats=%0d state=%h want 200/%h", b, v, {6'b0, 4'hF, 10'b0}); end
    Px_Ready = 0;
    @(negedge Clk); Reset_n = 1;
    @(negedge Clk);
    stream(0, -1, b, e);
    n_cmp++;
    if (b !== 784 || e !== 0) begin n_bad++; $display("FAIL restart_stream: beats=%0d errs=%0d want 784/0", b, e); end
    Clear = 1;
    @(negedge Clk); Clear = 0;
    @(negedge Clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream_basic();
    test_stall();
    test_timeout();
    test_start_clear();
    test_abort();
    test_draw();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
